audio_frame_sequencer: RTL

Frame-level controller between the codec audio FIFO interface and a shared, multi-cycle effect engine. It sequences the sample handshake: read one stereo frame, pass L then R through the single engine via a start/done handshake, then write the processed frame out when the output FIFO allows. It replaces the direct one-cycle passthrough path in `top`. It adds mute/bypass control, an engine watchdog, and a frame counter.

---
 rtl/audio_pkg.sv | 16 +
 rtl/audio_watchdog.sv | 32 +++
 rtl/audio_frame_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio frame sequencer slice.
package audio_pkg;

    localparam int AUDIO_W     = 32;
    localparam int ENG_TIMEOUT = 1023;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START_L = 3'd1,
        WAIT_L  = 3'd2,
        START_R = 3'd3,
        WAIT_R  = 3'd4,
        OUTPUT  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/audio_watchdog.sv
// Engine watchdog: counts enabled cycles since the last clear and flags the
// TIMEOUT-th enabled cycle.
import audio_pkg::*;

module audio_watchdog #(
    parameter int TIMEOUT = ENG_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // The first enabled cycle sees count 0, so the TIMEOUT-th sees TIMEOUT-1.
    assign expired = enable && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/audio_frame_sequencer.sv
// Frame sequencer: pops a stereo frame, runs L then R through a shared
// multi-cycle effect engine (or bypasses/mutes it), and pushes the result.
import audio_pkg::*;

module audio_frame_sequencer #(
    parameter int DATA_W  = AUDIO_W,
    parameter int TIMEOUT = ENG_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_N,
    input  logic                     mute,
    input  logic                     bypass,
    input  logic                     audio_in_available,
    input  logic                     audio_out_allowed,
    output logic                     read_audio_in,
    output logic                     write_audio_out,
    input  logic signed [DATA_W-1:0] audio_in_L,
    input  logic signed [DATA_W-1:0] audio_in_R,
    output logic signed [DATA_W-1:0] audio_out_L,
    output logic signed [DATA_W-1:0] audio_out_R,
    output logic                     eng_start,
    output logic                     eng_chan,
    output logic signed [DATA_W-1:0] eng_din,
    input  logic                     eng_done,
    input  logic signed [DATA_W-1:0] eng_dout,
    output logic [CNT_W-1:0]         frame_count,
    output logic                     timeout_err,
    output seq_state_t               state
);

    // Handshakes: read_audio_in pops a frame in the cycle it is high (IDLE
    // only, needs available && allowed); write_audio_out pushes in the cycle it
    // is high (OUTPUT only, follows allowed); eng_start is a single-cycle job
    // request and eng_done a single-cycle result strobe honoured only in WAIT_x.

    seq_state_t state_q, state_d;

    logic signed [DATA_W-1:0] in_l_q, in_r_q, res_l_q;
    logic                     mute_q, bypass_q;

    logic wd_clear, wd_enable, wd_expired;

    logic                     chan_finish;
    logic                     timeout_hit;
    logic signed [DATA_W-1:0] dry_sample;
    logic signed [DATA_W-1:0] chan_result;

    logic                     sel_mute, sel_bypass;
    logic signed [DATA_W-1:0] src_l, src_r;
    logic signed [DATA_W-1:0] out_l_d, out_r_d;
    logic                     load_out;

    assign state = state_q;

    audio_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        read_audio_in   = 1'b0;
        write_audio_out = 1'b0;
        eng_start       = 1'b0;
        wd_clear        = 1'b0;
        wd_enable       = 1'b0;
        case (state_q)
            IDLE: begin
                read_audio_in = audio_in_available && audio_out_allowed;
                if (read_audio_in) begin
                    state_d = (mute || bypass) ? OUTPUT : START_L;
                end
            end
            START_L: begin
                eng_start = 1'b1;
                wd_clear  = 1'b1;
                state_d   = WAIT_L;
            end
            WAIT_L: begin
                wd_enable = 1'b1;
                if (eng_done || wd_expired) begin
                    state_d = START_R;
                end
            end
            START_R: begin
                eng_start = 1'b1;
                wd_clear  = 1'b1;
                state_d   = WAIT_R;
            end
            WAIT_R: begin
                wd_enable = 1'b1;
                if (eng_done || wd_expired) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                write_audio_out = audio_out_allowed;
                if (audio_out_allowed) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A done in the expiry cycle wins, so the dry sample is used only when
    // the watchdog fires alone.
    always_comb begin
        chan_finish = wd_enable && (eng_done || wd_expired);
        timeout_hit = wd_expired && !eng_done;
        dry_sample  = (state_q == WAIT_L) ? in_l_q : in_r_q;
        chan_result = eng_done ? eng_dout : dry_sample;
    end

    // Entering OUTPUT from IDLE uses the live inputs, as the frame registers
    // load on that same edge; from WAIT_R the R result is still combinational.
    always_comb begin
        sel_mute   = (state_q == IDLE) ? mute       : mute_q;
        sel_bypass = (state_q == IDLE) ? bypass     : bypass_q;
        src_l      = (state_q == IDLE) ? audio_in_L : in_l_q;
        src_r      = (state_q == IDLE) ? audio_in_R : in_r_q;
        load_out   = (state_d == OUTPUT) && (state_q != OUTPUT);
        if (sel_mute) begin
            out_l_d = '0;
            out_r_d = '0;
        end else if (sel_bypass) begin
            out_l_d = src_l;
            out_r_d = src_r;
        end else begin
            out_l_d = res_l_q;
            out_r_d = chan_result;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            in_l_q      <= '0;
            in_r_q      <= '0;
            mute_q      <= 1'b0;
            bypass_q    <= 1'b0;
            res_l_q     <= '0;
            eng_din     <= '0;
            eng_chan    <= 1'b0;
            audio_out_L <= '0;
            audio_out_R <= '0;
            frame_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (read_audio_in) begin
                in_l_q   <= audio_in_L;
                in_r_q   <= audio_in_R;
                mute_q   <= mute;
                bypass_q <= bypass;
                if (!(mute || bypass)) begin
                    eng_din  <= audio_in_L;
                    eng_chan <= 1'b0;
                end
            end
            if (chan_finish && (state_q == WAIT_L)) begin
                res_l_q  <= chan_result;
                eng_din  <= in_r_q;
                eng_chan <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (load_out) begin
                audio_out_L <= out_l_d;
                audio_out_R <= out_r_d;
            end
            if (write_audio_out) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule
